// File: rtl/joystick_pkg.sv
// Shared types and default thresholds for the joystick ADC scanner.
package joystick_pkg;

    // Debounced per-axis position; the encoding is visible on axis_state.
    typedef enum logic [1:0] {
        CENTRE = 2'b00,
        HIGH   = 2'b01,
        LOW    = 2'b10
    } axis_state_t;

    // Per-axis scan phases, visited in this order for every axis.
    typedef enum logic [1:0] {
        SELECT,
        SETTLE,
        SAMPLE,
        UPDATE
    } scan_state_t;

    // Default classification thresholds in ADC counts.
    localparam int unsigned HI_TH_DEF = 'h950;
    localparam int unsigned LO_TH_DEF = 'h3E8;
    localparam int unsigned FLOOR_DEF = 'h50;
    localparam int unsigned HYST_DEF  = 'h40;

    // Width of the saturating debounce counter (holds STABLE_N up to 15).
    localparam int unsigned DEB_W = 4;

endpackage

// File: rtl/axis_classifier.sv
// One axis: hysteresis classification of the latest sample plus a
// consecutive-agreement debounce in front of the reported state.
module axis_classifier
    import joystick_pkg::*;
#(
    parameter int unsigned ADC_W    = 12,
    parameter int unsigned HI_TH    = HI_TH_DEF,
    parameter int unsigned LO_TH    = LO_TH_DEF,
    parameter int unsigned FLOOR    = FLOOR_DEF,
    parameter int unsigned HYST     = HYST_DEF,
    parameter int unsigned STABLE_N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [ADC_W-1:0] sample,
    output axis_state_t      state
);

    localparam logic [ADC_W-1:0] HI_C    = ADC_W'(HI_TH);
    localparam logic [ADC_W-1:0] LO_C    = ADC_W'(LO_TH);
    localparam logic [ADC_W-1:0] FLOOR_C = ADC_W'(FLOOR);
    // Release points for an already-deflected axis; both fit ADC_W without wrapping.
    localparam logic [ADC_W-1:0] HI_KEEP = ADC_W'(HI_TH - HYST);
    localparam logic [ADC_W-1:0] LO_KEEP = ADC_W'(LO_TH + HYST);
    localparam logic [DEB_W-1:0] STABLE_C = DEB_W'(STABLE_N);
    localparam logic [DEB_W-1:0] CNT_MAX  = '1;

    axis_state_t       raw;
    axis_state_t       cand;
    logic [DEB_W-1:0]  cnt;
    logic [DEB_W-1:0]  cnt_next;

    // Raw classification: floor first, then hysteresis hold, then plain thresholds.
    always_comb begin
        raw = CENTRE;
        if (sample <= FLOOR_C)
            raw = CENTRE;
        else if (state == HIGH && sample > HI_KEEP)
            raw = HIGH;
        else if (state == LOW && sample < LO_KEEP)
            raw = LOW;
        else if (sample > HI_C)
            raw = HIGH;
        else if (sample < LO_C)
            raw = LOW;
        else
            raw = CENTRE;
    end

    // Next agreement count: cleared on agreement with state, restarted on a new candidate.
    always_comb begin
        cnt_next = '0;
        if (raw == state)
            cnt_next = '0;
        else if (raw == cand && cnt != '0)
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        else
            cnt_next = DEB_W'(1);
    end

    // Debounce registers, advanced only in this axis's UPDATE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CENTRE;
            cand  <= CENTRE;
            cnt   <= '0;
        end else if (en) begin
            cand <= raw;
            cnt  <= cnt_next;
            if (cnt_next == STABLE_C)
                state <= raw;
        end
    end

endmodule

// File: rtl/joystick_scan.sv
// Round-robin ADC scanner: selects each axis channel, waits for the input
// to settle, samples it, and feeds that axis's classifier. Direction
// outputs are derived from the debounced states of axes 0 and 1.
module joystick_scan
    import joystick_pkg::*;
#(
    parameter int unsigned N_AXES        = 2,
    parameter int unsigned CHAN_W        = 3,
    parameter int unsigned ADC_W         = 12,
    parameter int unsigned SETTLE_CYCLES = 250,
    parameter int unsigned HI_TH         = HI_TH_DEF,
    parameter int unsigned LO_TH         = LO_TH_DEF,
    parameter int unsigned FLOOR         = FLOOR_DEF,
    parameter int unsigned HYST          = HYST_DEF,
    parameter int unsigned STABLE_N      = 3,
    parameter int unsigned SINGLE_DIR    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [CHAN_W-1:0]     chan,
    input  logic [ADC_W-1:0]      result,
    output logic [2*N_AXES-1:0]   axis_state,
    output logic                  up,
    output logic                  down,
    output logic                  left,
    output logic                  right,
    output logic                  dir_changed,
    output logic                  scan_done
);

    localparam int unsigned       SET_W       = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 2);
    localparam logic [CHAN_W-1:0] LAST_AXIS   = CHAN_W'(N_AXES - 1);

    scan_state_t       state;
    logic [CHAN_W-1:0] axis_idx;
    logic [SET_W-1:0]  settle_cnt;
    logic [ADC_W-1:0]  sample_q;
    axis_state_t       ax_st [N_AXES];

    logic up_n, down_n, left_n, right_n;

    // Scan sequencer: SELECT -> SETTLE -> SAMPLE -> UPDATE per axis, wrapping over all axes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SELECT;
            axis_idx   <= '0;
            chan       <= '0;
            settle_cnt <= '0;
            sample_q   <= '0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            unique case (state)
                SELECT: begin
                    chan       <= axis_idx;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST)
                        state <= SAMPLE;
                    else
                        settle_cnt <= settle_cnt + 1'b1;
                end
                SAMPLE: begin
                    sample_q <= result;
                    state    <= UPDATE;
                end
                UPDATE: begin
                    state <= SELECT;
                    if (axis_idx == LAST_AXIS) begin
                        axis_idx  <= '0;
                        scan_done <= 1'b1;
                    end else begin
                        axis_idx <= axis_idx + 1'b1;
                    end
                end
                default: state <= SELECT;
            endcase
        end
    end

    for (genvar g = 0; g < N_AXES; g++) begin : g_axis
        logic en;
        assign en = (state == UPDATE) && (axis_idx == CHAN_W'(g));

        axis_classifier #(
            .ADC_W    (ADC_W),
            .HI_TH    (HI_TH),
            .LO_TH    (LO_TH),
            .FLOOR    (FLOOR),
            .HYST     (HYST),
            .STABLE_N (STABLE_N)
        ) u_cls (
            .clk    (clk),
            .reset  (reset),
            .en     (en),
            .sample (sample_q),
            .state  (ax_st[g])
        );

        assign axis_state[2*g +: 2] = ax_st[g];
    end

    // Direction decode from axes 1 (vertical) and 0 (horizontal); vertical wins when exclusive.
    always_comb begin
        up_n    = (ax_st[1] == HIGH);
        down_n  = (ax_st[1] == LOW);
        left_n  = (ax_st[0] == HIGH);
        right_n = (ax_st[0] == LOW);
        if (SINGLE_DIR != 0 && ax_st[1] != CENTRE && ax_st[0] != CENTRE) begin
            left_n  = 1'b0;
            right_n = 1'b0;
        end
    end

    // Registered directions with a change pulse in the cycle they update.
    always_ff @(posedge clk) begin
        if (reset) begin
            up          <= 1'b0;
            down        <= 1'b0;
            left        <= 1'b0;
            right       <= 1'b0;
            dir_changed <= 1'b0;
        end else begin
            up          <= up_n;
            down        <= down_n;
            left        <= left_n;
            right       <= right_n;
            dir_changed <= {up_n, down_n, left_n, right_n} != {up, down, left, right};
        end
    end

endmodule

// File: tb/tb_joystick_scan.sv
// Bench for joystick_scan: a default instance (2 axes, exclusive directions)
// and a 4-axis instance with independent directions, each driven by an ADC
// model and compared scan by scan against a behavioural reference.
module tb_joystick_scan;

    localparam int STABLE_N = 3;
    localparam int SETTLE   = 250;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [2:0]  chan_a, chan_b;
    logic [11:0] res_a, res_b;
    logic [3:0]  ast_a;
    logic [7:0]  ast_b;
    logic up_a, down_a, left_a, right_a, dc_a, sd_a;
    logic up_b, down_b, left_b, right_b, dc_b, sd_b;

    logic [11:0] val [2][8];
    assign res_a = val[0][chan_a];
    assign res_b = val[1][chan_b];

    joystick_scan dut_a (
        .clk(clk), .reset(rst_a), .chan(chan_a), .result(res_a), .axis_state(ast_a),
        .up(up_a), .down(down_a), .left(left_a), .right(right_a),
        .dir_changed(dc_a), .scan_done(sd_a)
    );

    joystick_scan #(.N_AXES(4), .SINGLE_DIR(0)) dut_b (
        .clk(clk), .reset(rst_b), .chan(chan_b), .result(res_b), .axis_state(ast_b),
        .up(up_b), .down(down_b), .left(left_b), .right(right_b),
        .dir_changed(dc_b), .scan_done(sd_b)
    );

    // Uniform views of both instances, indexed by instance number.
    logic       sd [2], dc [2];
    logic [3:0] dirs [2];
    logic [7:0] ast [2];
    logic [2:0] chn [2];
    always_comb begin
        sd[0] = sd_a;  sd[1] = sd_b;
        dc[0] = dc_a;  dc[1] = dc_b;
        dirs[0] = {up_a, down_a, left_a, right_a};
        dirs[1] = {up_b, down_b, left_b, right_b};
        ast[0] = {4'b0, ast_a};
        ast[1] = ast_b;
        chn[0] = chan_a;
        chn[1] = chan_b;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: positions 0=centre 1=high 2=low, plus recent raw history.
    int nax [2];
    int single [2];
    int mst [2][8];
    int hlen [2][8];
    int hist [2][8][16];

    function automatic int classify(input int st, input int r);
        if (r <= 'h50) return 0;
        if (st == 1 && r > 'h950 - 'h40) return 1;
        if (st == 2 && r < 'h3E8 + 'h40) return 2;
        if (r > 'h950) return 1;
        if (r < 'h3E8) return 2;
        return 0;
    endfunction

    function automatic logic [3:0] model_dirs(input int d);
        logic u, dn, l, r;
        u  = (mst[d][1] == 1);
        dn = (mst[d][1] == 2);
        l  = (mst[d][0] == 1);
        r  = (mst[d][0] == 2);
        if (single[d] != 0 && mst[d][1] != 0 && mst[d][0] != 0) begin
            l = 1'b0;
            r = 1'b0;
        end
        return {u, dn, l, r};
    endfunction

    // Position moves once the last STABLE_N raw results all name the same new position.
    task automatic model_axis(input int d, input int a, input int r);
        int  raw;
        bit  agree;
        raw = classify(mst[d][a], r);
        if (raw == mst[d][a]) begin
            hlen[d][a] = 0;
        end else begin
            for (int k = 15; k > 0; k--) hist[d][a][k] = hist[d][a][k-1];
            hist[d][a][0] = raw;
            if (hlen[d][a] < 16) hlen[d][a]++;
            agree = (hlen[d][a] >= STABLE_N);
            for (int k = 0; k < STABLE_N; k++)
                if (hist[d][a][k] != raw) agree = 1'b0;
            if (agree) begin
                mst[d][a]  = raw;
                hlen[d][a] = 0;
            end
        end
    endtask

    task automatic model_reset(input int d);
        for (int a = 0; a < 8; a++) begin
            mst[d][a]  = 0;
            hlen[d][a] = 0;
        end
    endtask

    function automatic logic [7:0] model_ast(input int d);
        logic [7:0] e;
        e = '0;
        for (int a = 0; a < nax[d]; a++) e[2*a +: 2] = 2'(mst[d][a]);
        return e;
    endfunction

    // Wait for a scan_done of instance d, then step to the first SETTLE cycle of the next scan.
    task automatic sync(input int d);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (sd[d]) seen = 1'b1;
        end
        check("sync scan_done", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    // Apply one scan's worth of channel values and compare the end-of-scan outputs.
    task automatic do_scan(input int d, input int v0, input int v1, input int v2, input int v3);
        int         cyc, pulses, exp_p;
        bit         seen;
        logic [3:0] prev, now;
        val[d][0] = 12'(v0);
        val[d][1] = 12'(v1);
        val[d][2] = 12'(v2);
        val[d][3] = 12'(v3);
        prev  = model_dirs(d);
        exp_p = 0;
        for (int a = 0; a < nax[d]; a++) begin
            model_axis(d, a, int'(val[d][a]));
            now = model_dirs(d);
            if (now != prev) exp_p++;
            prev = now;
        end
        cyc    = 0;
        pulses = 0;
        seen   = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (dc[d]) pulses++;
            if (sd[d]) seen = 1'b1;
        end
        check("scan_done seen", 32'(seen), 32'd1);
        check("scan period", 32'(cyc + 1), 32'(nax[d] * (SETTLE + 2)));
        @(negedge clk);
        if (dc[d]) pulses++;
        check("scan_done width", 32'(sd[d]), 32'd0);
        check("axis_state", 32'(ast[d]), 32'(model_ast(d)));
        check("directions", 32'(dirs[d]), 32'(model_dirs(d)));
        check("dir_changed pulses", 32'(pulses), 32'(exp_p));
    endtask

    function automatic int pick();
        case ($urandom_range(0, 14))
            0:  return 'h030;
            1:  return 'h050;
            2:  return 'h051;
            3:  return 'h100;
            4:  return 'h3E7;
            5:  return 'h3E8;
            6:  return 'h427;
            7:  return 'h428;
            8:  return 'h800;
            9:  return 'h910;
            10: return 'h911;
            11: return 'h950;
            12: return 'h951;
            13: return 'hA00;
            default: return 'hFFF;
        endcase
    endfunction

    task automatic check_idle(input int d, input string tag);
        check({tag, " axis_state"}, 32'(ast[d]), 32'd0);
        check({tag, " dirs"}, 32'(dirs[d]), 32'd0);
        check({tag, " dir_changed"}, 32'(dc[d]), 32'd0);
        check({tag, " scan_done"}, 32'(sd[d]), 32'd0);
        check({tag, " chan"}, 32'(chn[d]), 32'd0);
    endtask

    initial begin
        int cur [4];
        int cyc;

        nax[0] = 2;  single[0] = 1;
        nax[1] = 4;  single[1] = 0;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            for (int a = 0; a < 8; a++) val[d][a] = '0;
        end

        // Reset both instances
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check_idle(0, "reset A");
        check_idle(1, "reset B");
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("post-reset chan A", 32'(chan_a), 32'd0);

        // Hold ch1 high, ch0 mid: up after the third scan
        repeat (3) do_scan(0, 'h800, 'hA00, 0, 0);
        check("up after 3 scans", 32'(dirs[0]), 32'b1000);

        // Inside the hysteresis band up is kept; at 'h900 it releases
        repeat (2) do_scan(0, 'h800, 'h920, 0, 0);
        check("up held by hysteresis", 32'(dirs[0]), 32'b1000);
        repeat (3) do_scan(0, 'h800, 'h900, 0, 0);
        check("up released", 32'(dirs[0]), 32'b0000);

        // Below floor is centre; a genuine low reading gives right
        repeat (2) do_scan(0, 'h030, 'h800, 0, 0);
        check("floor is centre", 32'(dirs[0]), 32'b0000);
        repeat (3) do_scan(0, 'h100, 'h800, 0, 0);
        check("right asserted", 32'(dirs[0]), 32'b0001);

        // Both axes deflected: vertical only
        repeat (3) do_scan(0, 'hA00, 'hA00, 0, 0);
        check("single dir masks left", 32'(dirs[0]), 32'b1000);

        // Return to centre, then alternate ch1 every scan: never debounces
        repeat (3) do_scan(0, 'h800, 'h800, 0, 0);
        for (int i = 0; i < 6; i++) begin
            do_scan(0, 'h800, (i % 2 == 0) ? 'hA00 : 'h800, 0, 0);
            check("alternating never up", 32'(up_a), 32'd0);
        end

        // Randomized values held for random stretches
        cur[0] = 'h800; cur[1] = 'h800; cur[2] = 0; cur[3] = 0;
        for (int i = 0; i < 20; i++) begin
            for (int a = 0; a < 2; a++)
                if ($urandom_range(0, 2) == 0) cur[a] = pick();
            do_scan(0, cur[0], cur[1], 0, 0);
        end

        // Four-axis instance with independent directions
        sync(1);
        repeat (3) do_scan(1, 'hA00, 'hA00, 'hA00, 'h100);
        check("independent up+left", 32'(dirs[1]), 32'b1010);
        for (int i = 0; i < 4; i++) begin
            for (int a = 0; a < 4; a++)
                if ($urandom_range(0, 1) == 0) cur[a] = pick();
            do_scan(1, cur[0], cur[1], cur[2], cur[3]);
        end
        repeat (3) do_scan(1, 'hA00, 'h100, 'hFFF, 'h200);

        // Reset in the middle of axis 1's settle window
        cyc = 0;
        while (chn[1] != 3'd1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached axis 1", 32'(chn[1]), 32'd1);
        repeat (100) @(negedge clk);
        rst_b = 1'b1;
        for (int a = 0; a < 8; a++) val[1][a] = '0;
        model_reset(1);
        repeat (2) @(negedge clk);
        check_idle(1, "mid-scan reset");
        rst_b = 1'b0;
        @(negedge clk);
        check_idle(1, "after reset");
        repeat (2) do_scan(1, 'h100, 'hA00, 'h030, 'hA00);
        repeat (2) do_scan(1, 'h100, 'hA00, 'h030, 'hA00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/joystick_scan.md
JOYSTICK_SCAN -- requirements
Module: joystick_scan

Interface
REQ-001 Parameter N_AXES, default 2: number of ADC axes scanned; axis i uses ADC channel i; range 2..8.
REQ-002 Parameter CHAN_W, default 3: ADC channel-select width.
REQ-003 Parameter ADC_W, default 12: ADC result width.
REQ-004 Parameter SETTLE_CYCLES, default 250: cycles between a channel change and its sample; minimum 2.
REQ-005 Parameters HI_TH 'h950, LO_TH 'h3E8, FLOOR 'h50, HYST 'h40: classification thresholds; HI_TH-HYST > LO_TH+HYST is required.
REQ-006 Parameter STABLE_N, default 3: consecutive agreeing samples needed to change an axis state; range 1..15.
REQ-007 Parameter SINGLE_DIR, default 1: 1 = at most one direction output high; 0 = independent axes.
REQ-008 clk  in  1  system clock; the only clock.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 chan  out  CHAN_W  ADC channel select.
REQ-011 result  in  ADC_W  ADC conversion result for the selected channel.
REQ-012 axis_state  out  2*N_AXES  debounced state per axis, 2 bits each: 00 centre, 01 high, 10 low.
REQ-013 up, down, left, right  out  1 each  directions: axis 1 high=up, low=down; axis 0 high=left, low=right.
REQ-014 dir_changed  out  1  one-cycle pulse when any of up/down/left/right changes.
REQ-015 scan_done  out  1  one-cycle pulse after the last axis of a scan is classified.

Function
REQ-016 FSM states SELECT, SETTLE, SAMPLE, UPDATE; SELECT -> SETTLE -> SAMPLE -> UPDATE -> SELECT, unconditionally.
REQ-017 SELECT: one cycle; chan <= current axis index; settle counter cleared.
REQ-018 SETTLE: SETTLE_CYCLES-1 cycles; result is ignored.
REQ-019 SAMPLE: one cycle; result registered for the current axis.
REQ-020 UPDATE: one cycle; the current axis classifier is updated; axis index increments and wraps from N_AXES-1 to 0; scan_done pulses on that wrap.
REQ-021 Sample period per axis = SETTLE_CYCLES+2 cycles; full scan = N_AXES*(SETTLE_CYCLES+2) cycles.
REQ-022 Raw classification, with result <= FLOOR taken first: result <= FLOOR -> centre (disconnected or rail).
REQ-023 Raw classification from debounced centre: > HI_TH -> high; FLOOR < result < LO_TH -> low; else centre.
REQ-024 Raw classification from debounced high: stays high while result > HI_TH-HYST; otherwise reclassified as from centre.
REQ-025 Raw classification from debounced low: stays low while result < LO_TH+HYST; otherwise reclassified as from centre.
REQ-026 Debounce: a per-axis saturating count of consecutive raw results equal to a candidate and different from the debounced state.
REQ-027 Debounce: the count resets to 1 when the candidate changes and to 0 when the raw result equals the debounced state.
REQ-028 Debounce: the debounced state takes the candidate in the UPDATE cycle where the count reaches STABLE_N.
REQ-029 axis_state is registered; it is valid the cycle after UPDATE.
REQ-030 Directions are derived registered from axis_state one cycle after it changes; dir_changed pulses in that same cycle.
REQ-031 SINGLE_DIR=1: with both axes non-centre, only the vertical direction asserts; horizontal is masked.
REQ-032 Axes 2..N_AXES-1 are scanned and reported on axis_state only; they drive no direction output.
REQ-033 All comparisons unsigned, ADC_W bits wide; HI_TH-HYST and LO_TH+HYST are computed as constants and must not wrap.

Reset
REQ-034 Reset forces: FSM to SELECT, axis index 0, chan 0, all axis_state centre, debounce counts 0.
REQ-035 Reset forces: up/down/left/right 0, dir_changed 0, scan_done 0.
REQ-036 Reset asserted mid-scan aborts the scan with no output pulse; the first cycle after deassertion is SELECT for axis 0.

Structure
REQ-037 Package joystick_pkg holds the axis_state_t enum (CENTRE=00, HIGH=01, LOW=10), the scan_state_t enum and the default threshold constants.
REQ-038 Sub-module axis_classifier (hysteresis plus debounce, one axis) is instantiated N_AXES times via generate and enabled in UPDATE for its index.

Verification
REQ-039 Scenario: defaults; hold result 'hA00 on ch1, 'h800 on ch0 -> up=1 after 3 scans, left=right=down=0, one dir_changed pulse.
REQ-040 Scenario: up asserted, ch1 result 'h920 (> HI_TH-HYST) -> up stays 1; then 'h900 for 3 scans -> up=0, one dir_changed pulse.
REQ-041 Scenario: ch0 result 'h30 (below FLOOR) -> left=right=0; ch0 result 'h100 for 3 scans -> right=1.
REQ-042 Scenario: SINGLE_DIR=1, ch1 'hA00 and ch0 'hA00 -> up=1, left=0; SINGLE_DIR=0 with the same inputs -> up=1, left=1.
REQ-043 Scenario: ch1 alternates 'hA00 and 'h800 on successive scans -> up never asserts (debounce).
REQ-044 Scenario: reset pulsed at settle count 100 of axis 1 -> all outputs 0; chan=0 on the cycle after deassertion; N_AXES=4 scan_done period = 1008 cycles.
